// File: rtl/parking_allocator_pkg.sv
// Shared constants and FSM encoding for the parking allocator.
// Slot and counter widths are fixed for the largest supported lot (8 slots).
package parking_allocator_pkg;

   localparam int DEFAULT_NUM_SLOTS = 8;
   localparam int SLOT_W            = 3;
   localparam int COUNT_W           = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALLOC = 2'd1,
      ST_GRANT = 2'd2,
      ST_DENY  = 2'd3
   } state_t;

endpackage

// File: rtl/parking_allocator_if.sv
// Entry/exit signalling between the registration stage, exit gates and the allocator.
// reg_p/reg_q are levels (only rising edges matter); exit_req, grant, deny and exit_err
// are single-cycle pulses with no back-pressure; exit_slot is meaningful only with exit_req.
interface parking_allocator_if
   import parking_allocator_pkg::*;
#(
   parameter int NUM_SLOTS = DEFAULT_NUM_SLOTS
) ();

   logic                 reg_p;
   logic                 reg_q;
   logic                 exit_req;
   logic [SLOT_W-1:0]    exit_slot;
   logic                 grant;
   logic                 deny;
   logic [SLOT_W-1:0]    slot_id;
   logic [NUM_SLOTS-1:0] occupied;
   logic [COUNT_W-1:0]   free_count;
   logic                 full;
   logic                 exit_err;

   modport master (
      output reg_p, reg_q, exit_req, exit_slot,
      input  grant, deny, slot_id, occupied, free_count, full, exit_err
   );

   modport slave (
      input  reg_p, reg_q, exit_req, exit_slot,
      output grant, deny, slot_id, occupied, free_count, full, exit_err
   );

endinterface

// File: rtl/parking_allocator_free_slot_finder.sv
// Lowest-index free slot search over the occupancy bitmap.
module free_slot_finder
   import parking_allocator_pkg::*;
#(
   parameter int NUM_SLOTS = DEFAULT_NUM_SLOTS
) (
   input  logic [NUM_SLOTS-1:0] occupancy,
   output logic [SLOT_W-1:0]    index,
   output logic                 any_free
);

   // Scanning downwards lets the lowest free index overwrite higher ones.
   always_comb begin
      index = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!occupancy[i]) index = SLOT_W'(i);
      end
   end

   assign any_free = ~&occupancy;

endmodule

// File: rtl/parking_allocator.sv
// Parking lot allocator: edge-detects registration decisions, assigns the lowest free
// slot, and tracks occupancy and free count while cars exit.
module parking_allocator
   import parking_allocator_pkg::*;
#(
   parameter int NUM_SLOTS = DEFAULT_NUM_SLOTS
) (
   input  logic                clock,
   input  logic                reset,
   parking_allocator_if.slave  bus,
   output state_t              fsm_state
);

   state_t               state, state_n;
   logic                 reg_p_d, reg_q_d;
   logic                 rise_p, rise_q;
   logic [NUM_SLOTS-1:0] occ, occ_n;
   logic [SLOT_W-1:0]    slot_q;
   logic [COUNT_W-1:0]   free_q, free_n;
   logic                 exit_err_q;
   logic [SLOT_W-1:0]    find_idx;
   logic                 any_free;
   logic                 do_alloc;
   logic                 exit_hit;

   free_slot_finder #(.NUM_SLOTS(NUM_SLOTS)) u_finder (
      .occupancy (occ),
      .index     (find_idx),
      .any_free  (any_free)
   );

   assign rise_p = bus.reg_p & ~reg_p_d;
   assign rise_q = bus.reg_q & ~reg_q_d;

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:  if (rise_q) state_n = ST_DENY;
                   else if (rise_p) state_n = ST_ALLOC;
         ST_ALLOC: state_n = any_free ? ST_GRANT : ST_DENY;
         ST_GRANT: state_n = ST_IDLE;
         ST_DENY:  state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   assign do_alloc = (state == ST_ALLOC) && any_free;

   // Allocation searches pre-exit occupancy, so the two slots touched always differ.
   always_comb begin
      occ_n    = occ;
      exit_hit = 1'b0;
      free_n   = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (bus.exit_req && bus.exit_slot == SLOT_W'(i) && occ[i]) begin
            exit_hit = 1'b1;
            occ_n[i] = 1'b0;
         end
         if (do_alloc && find_idx == SLOT_W'(i)) occ_n[i] = 1'b1;
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!occ_n[i]) free_n = free_n + COUNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         reg_p_d    <= 1'b0;
         reg_q_d    <= 1'b0;
         occ        <= '0;
         slot_q     <= '0;
         free_q     <= COUNT_W'(NUM_SLOTS);
         exit_err_q <= 1'b0;
      end else begin
         state      <= state_n;
         reg_p_d    <= bus.reg_p;
         reg_q_d    <= bus.reg_q;
         occ        <= occ_n;
         free_q     <= free_n;
         exit_err_q <= bus.exit_req & ~exit_hit;
         if (do_alloc) slot_q <= find_idx;
      end
   end

   assign bus.grant      = (state == ST_GRANT);
   assign bus.deny       = (state == ST_DENY);
   assign bus.slot_id    = slot_q;
   assign bus.occupied   = occ;
   assign bus.free_count = free_q;
   assign bus.full       = (free_q == '0);
   assign bus.exit_err   = exit_err_q;
   assign fsm_state      = state;

endmodule

// File: tb/tb_parking_allocator.sv
// Randomized bench for parking_allocator against a slot-array reference model,
// plus a small 2-slot instance for out-of-range exits.
module tb_parking_allocator;
   import parking_allocator_pkg::*;

   logic   clock;
   logic   reset;
   state_t fsm_state;
   state_t fsm_state2;

   int checks;
   int errors;

   bit [7:0]   m_occ;
   logic [2:0] exp_q[$];

   parking_allocator_if #(.NUM_SLOTS(8)) pif ();
   parking_allocator_if #(.NUM_SLOTS(2)) pif2 ();

   parking_allocator #(.NUM_SLOTS(8)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (pif.slave),
      .fsm_state (fsm_state)
   );

   parking_allocator #(.NUM_SLOTS(2)) dut2 (
      .clock     (clock),
      .reset     (reset),
      .bus       (pif2.slave),
      .fsm_state (fsm_state2)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic int lowest_free(input bit [7:0] v);
      for (int i = 0; i < 8; i++) if (!v[i]) return i;
      return -1;
   endfunction

   task automatic check_lot(input string tag);
      check({tag, "_occ"},  {24'd0, pif.occupied}, {24'd0, m_occ});
      check({tag, "_free"}, {28'd0, pif.free_count}, 32'(8 - $countones(m_occ)));
      check({tag, "_full"}, {31'd0, pif.full}, {31'd0, (m_occ == 8'hFF)});
   endtask

   // ---------------- driver tasks (start and end at a falling edge) ----------------
   task automatic do_entry(input bit p, input bit q, input bit ex_en, input logic [2:0] ex_slot);
      bit [7:0] pre;
      int       lo;
      bit       ex_ok;
      pif.reg_p = p;
      pif.reg_q = q;
      @(negedge clock);
      if (q) begin
         check("deny_q", {31'd0, pif.deny}, 32'd1);
         check("grant_q", {31'd0, pif.grant}, 32'd0);
      end else begin
         check("early_grant", {31'd0, pif.grant}, 32'd0);
         check("early_deny", {31'd0, pif.deny}, 32'd0);
         if (ex_en) begin
            pif.exit_req  = 1'b1;
            pif.exit_slot = ex_slot;
         end
         pre   = m_occ;
         lo    = lowest_free(pre);
         ex_ok = ex_en && pre[ex_slot];
         if (lo >= 0) begin
            m_occ[lo] = 1'b1;
            exp_q.push_back(lo[2:0]);
         end
         if (ex_ok) m_occ[ex_slot] = 1'b0;
         @(negedge clock);
         pif.exit_req = 1'b0;
         if (lo >= 0) begin
            check("grant", {31'd0, pif.grant}, 32'd1);
            check("deny_on_grant", {31'd0, pif.deny}, 32'd0);
            check("slot_id", {29'd0, pif.slot_id}, {29'd0, exp_q.pop_front()});
         end else begin
            check("deny_full", {31'd0, pif.deny}, 32'd1);
            check("grant_full", {31'd0, pif.grant}, 32'd0);
         end
         if (ex_en) check("alloc_exit_err", {31'd0, pif.exit_err}, {31'd0, !ex_ok});
      end
      check_lot("entry");
      pif.reg_p = 1'b0;
      pif.reg_q = 1'b0;
      @(negedge clock);
      check("pulse_end_g", {31'd0, pif.grant}, 32'd0);
      check("pulse_end_d", {31'd0, pif.deny}, 32'd0);
   endtask

   task automatic do_exit(input logic [2:0] slot);
      bit ok;
      pif.exit_req  = 1'b1;
      pif.exit_slot = slot;
      ok = m_occ[slot];
      if (ok) m_occ[slot] = 1'b0;
      @(negedge clock);
      pif.exit_req = 1'b0;
      check("exit_err", {31'd0, pif.exit_err}, {31'd0, !ok});
      check_lot("exit");
      @(negedge clock);
      check("exit_err_end", {31'd0, pif.exit_err}, 32'd0);
   endtask

   task automatic e2_exit(input logic [2:0] slot, input bit exp_err, input logic [1:0] exp_occ);
      pif2.exit_req  = 1'b1;
      pif2.exit_slot = slot;
      @(negedge clock);
      pif2.exit_req = 1'b0;
      check("n2_exit_err", {31'd0, pif2.exit_err}, {31'd0, exp_err});
      check("n2_occ", {30'd0, pif2.occupied}, {30'd0, exp_occ});
      @(negedge clock);
   endtask

   task automatic e2_entry(input bit exp_grant, input logic [2:0] exp_slot, input logic [1:0] exp_occ);
      pif2.reg_p = 1'b1;
      repeat (2) @(negedge clock);
      check("n2_grant", {31'd0, pif2.grant}, {31'd0, exp_grant});
      check("n2_deny", {31'd0, pif2.deny}, {31'd0, !exp_grant});
      if (exp_grant) check("n2_slot", {29'd0, pif2.slot_id}, {29'd0, exp_slot});
      check("n2_occ", {30'd0, pif2.occupied}, {30'd0, exp_occ});
      pif2.reg_p = 1'b0;
      @(negedge clock);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      checks = 0;
      errors = 0;
      m_occ  = '0;
      reset  = 1'b0;
      pif.reg_p = 1'b0;  pif.reg_q = 1'b0;  pif.exit_req = 1'b0;  pif.exit_slot = '0;
      pif2.reg_p = 1'b0; pif2.reg_q = 1'b0; pif2.exit_req = 1'b0; pif2.exit_slot = '0;
      repeat (3) @(negedge clock);

      check("rst_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
      check("rst_grant", {31'd0, pif.grant}, 32'd0);
      check("rst_deny", {31'd0, pif.deny}, 32'd0);
      check("rst_slot", {29'd0, pif.slot_id}, 32'd0);
      check("rst_err", {31'd0, pif.exit_err}, 32'd0);
      check_lot("rst");
      reset = 1'b1;
      @(negedge clock);

      // single entry, then fill the lot, then one more is refused
      for (int i = 0; i < 9; i++) do_entry(1'b1, 1'b0, 1'b0, 3'd0);

      // exit on a full lot coinciding with a refused allocation, then slot 6 reused
      do_entry(1'b1, 1'b0, 1'b1, 3'd6);
      do_entry(1'b1, 1'b0, 1'b0, 3'd0);

      // down to 8'h0F, free slot 1, re-enter into slot 1
      for (int s = 7; s >= 4; s--) do_exit(3'(s));
      do_exit(3'd1);
      do_entry(1'b1, 1'b0, 1'b0, 3'd0);

      // simultaneous approve/refuse, refuse alone, exit on a free slot
      do_entry(1'b1, 1'b1, 1'b0, 3'd0);
      do_entry(1'b0, 1'b1, 1'b0, 3'd0);
      do_exit(3'd5);

      // a refuse edge arriving during ALLOC is dropped and never replayed
      pif.reg_p = 1'b1;
      @(negedge clock);
      pif.reg_q = 1'b1;
      m_occ[lowest_free(m_occ)] = 1'b1;
      @(negedge clock);
      check("drop_grant", {31'd0, pif.grant}, 32'd1);
      repeat (2) begin
         @(negedge clock);
         check("drop_no_deny", {31'd0, pif.deny}, 32'd0);
      end
      check_lot("drop");
      pif.reg_p = 1'b0;
      pif.reg_q = 1'b0;
      @(negedge clock);

      // randomized traffic
      for (int n = 0; n < 150; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 4)      do_entry(1'b1, 1'b0, 1'b0, 3'd0);
         else if (r == 5) do_entry(1'b0, 1'b1, 1'b0, 3'd0);
         else if (r == 6) do_entry(1'b1, 1'b1, 1'b0, 3'd0);
         else if (r == 7) do_entry(1'b1, 1'b0, 1'b1, 3'($urandom_range(0, 7)));
         else             do_exit(3'($urandom_range(0, 7)));
      end

      // reset during ALLOC aborts; reg_p still high counts as a new edge afterwards
      pif.reg_p = 1'b1;
      @(negedge clock);
      check("pre_rst_state", {30'd0, fsm_state}, {30'd0, ST_ALLOC});
      reset = 1'b0;
      m_occ = '0;
      exp_q.delete();
      #1;
      check("rst_mid_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
      @(negedge clock);
      check("rst_mid_grant", {31'd0, pif.grant}, 32'd0);
      check_lot("rst_mid");
      reset = 1'b1;
      @(negedge clock);
      check("rel_early", {31'd0, pif.grant}, 32'd0);
      @(negedge clock);
      check("rel_grant", {31'd0, pif.grant}, 32'd1);
      check("rel_slot", {29'd0, pif.slot_id}, 32'd0);
      m_occ[0] = 1'b1;
      check_lot("rel");
      pif.reg_p = 1'b0;
      @(negedge clock);

      // two-slot lot: out-of-range and free-slot exits, then fill and refuse
      e2_exit(3'd3, 1'b1, 2'b00);
      e2_exit(3'd1, 1'b1, 2'b00);
      e2_entry(1'b1, 3'd0, 2'b01);
      e2_entry(1'b1, 3'd1, 2'b11);
      check("n2_full", {31'd0, pif2.full}, 32'd1);
      e2_entry(1'b0, 3'd0, 2'b11);
      e2_exit(3'd1, 1'b0, 2'b01);
      check("n2_free", {28'd0, pif2.free_count}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
